// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default line rate, FSM state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned FRAME_BITS   = 11;
    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick is high on the last cycle of each CLKS_PER_BIT-cycle period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop; all outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       UART_Tx
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 clear;
    logic                 tick;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ PARITY_ODD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Counter is held in IDLE so every bit period starts from zero.
        clear = (state_q == ST_IDLE) || (state_d != state_q);

        // Outputs derive from next state so they are flop-driven yet aligned with it.
        unique case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign UART_Tx = line_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default-rate even-parity instance plus a fast odd-parity instance.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1;
    logic       s0, s1;
    logic       l0, b0, dn0;
    logic       l1, b1, dn1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx u_even (
        .clk     (clk),
        .rst     (rst),
        .tx_data (d0),
        .tx_start(s0),
        .tx_busy (b0),
        .tx_done (dn0),
        .UART_Tx (l0)
    );

    // 1 MHz / 100 kbaud gives 10 clocks per bit.
    uart_tx #(
        .CLK_FREQ  (1_000_000),
        .BAUD      (100_000),
        .PARITY_ODD(1'b1)
    ) u_odd (
        .clk     (clk),
        .rst     (rst),
        .tx_data (d1),
        .tx_start(s1),
        .tx_busy (b1),
        .tx_done (dn1),
        .UART_Tx (l1)
    );

    // Called at acceptance edge + 1; checks every cycle of the frame and the done cycle.
    task automatic check_frame(input bit sel, input logic [7:0] data, input logic par,
                               input int dis_at);
        int          cpb = sel ? 10 : 434;
        logic [10:0] fr  = {1'b1, par, data, 1'b0};
        logic [10:0] rx  = '0;
        logic [2:0]  got;
        logic [2:0]  first_bad;
        bit          bad;
        for (int b = 0; b < 11; b++) begin
            bad       = 1'b0;
            first_bad = '0;
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                got = sel ? {l1, b1, dn1} : {l0, b0, dn0};
                if (c == cpb / 2) rx[b] = got[2];
                if (got !== {fr[b], 1'b1, 1'b0} && !bad) begin
                    bad       = 1'b1;
                    first_bad = got;
                end
                if (dis_at >= 0) begin
                    if (b * cpb + c == dis_at) begin
                        s0 = 1'b1;
                        d0 = 8'h34;
                    end else if (b * cpb + c == dis_at + 1) begin
                        s0 = 1'b0;
                    end
                end
            end
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL frame_bit%0d data=%h: line/busy/done=%b required %b",
                         b, data, first_bad, {fr[b], 1'b1, 1'b0});
            end
        end
        @(negedge clk);
        got = sel ? {l1, b1, dn1} : {l0, b0, dn0};
        n_checks++;
        if (got !== 3'b101) begin
            n_fail++;
            $display("FAIL done_cycle data=%h: line/busy/done=%b required 101", data, got);
        end
        n_checks++;
        if (rx[8:1] !== data) begin
            n_fail++;
            $display("FAIL rx_data: got %h required %h", rx[8:1], data);
        end
        n_checks++;
        if ((^rx[9:1]) !== sel) begin
            n_fail++;
            $display("FAIL rx_parity data=%h: xor=%b required %b", data, ^rx[9:1], sel);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] data, input logic par, input int dis_at);
        logic [2:0] got;
        @(negedge clk);
        if (sel) begin d1 = data; s1 = 1'b1; end
        else     begin d0 = data; s0 = 1'b1; end
        @(posedge clk);
        #1;
        if (sel) s1 = 1'b0;
        else     s0 = 1'b0;
        check_frame(sel, data, par, dis_at);
        @(negedge clk);
        got = sel ? {l1, b1, dn1} : {l0, b0, dn0};
        n_checks++;
        if (got !== 3'b100) begin
            n_fail++;
            $display("FAIL after_done data=%h: line/busy/done=%b required 100", data, got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s0  = 1'b0;
        s1  = 1'b0;
        d0  = '0;
        d1  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({l0, b0, dn0} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_even: %b required 100", {l0, b0, dn0});
        end
        n_checks++;
        if ({l1, b1, dn1} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_odd: %b required 100", {l1, b1, dn1});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({l0, b0, dn0, l1, b1, dn1} !== 6'b100100) begin
            n_fail++;
            $display("FAIL idle_after_reset: %b required 100100", {l0, b0, dn0, l1, b1, dn1});
        end
    endtask

    task automatic test_basic();
        send(1'b0, 8'h0C, 1'b0, -1);
    endtask

    task automatic test_parity();
        send(1'b0, 8'h08, 1'b1, -1);
        send(1'b0, 8'hAA, 1'b0, -1);
        send(1'b0, 8'h55, 1'b0, -1);
        send(1'b1, 8'h07, 1'b0, -1);
        send(1'b1, 8'hFF, 1'b1, -1);
    endtask

    task automatic test_ignore_busy();
        bit bad = 1'b0;
        send(1'b0, 8'h12, 1'b0, 2000);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ({l0, b0, dn0} !== 3'b100) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL no_queued_frame: line/busy/done left idle (100) after 0x12 frame");
        end
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        @(negedge clk);
        d0 = 8'h0C;
        s0 = 1'b1;
        @(posedge clk);
        #1;
        s0 = 1'b0;
        repeat (4 * 434 + 200) @(negedge clk);
        n_checks++;
        if ({l0, b0} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_bit3_line: line/busy=%b required 11", {l0, b0});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({l0, b0, dn0} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_frame: %b required 100", {l0, b0, dn0});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ({l0, b0, dn0} !== 3'b100) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL truncated_frame: output left idle (100) after mid-frame reset");
        end
        send(1'b0, 8'h08, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] got;
        @(negedge clk);
        d0 = 8'h0C;
        s0 = 1'b1;
        @(posedge clk);
        #1;
        d0 = 8'h08;
        check_frame(1'b0, 8'h0C, 1'b0, -1);
        @(posedge clk);
        #1;
        s0 = 1'b0;
        check_frame(1'b0, 8'h08, 1'b1, -1);
        @(negedge clk);
        got = {l0, b0, dn0};
        n_checks++;
        if (got !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_end: line/busy/done=%b required 100", got);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the RISC-V single-cycle SoC's memory-mapped UART peripheral. It serialises one byte per request into an 11-bit frame: start bit, 8 data bits LSB first, one parity bit, and a stop bit. The frame format and baud rate are identical to what the UART receiver accepts. It drives the SoC's `UART_Tx` pin, and the CPU-side UART register block feeds it through a start/busy/done handshake.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate. Bit period is `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer division, 434 by default (≈8.68 µs).
- `PARITY_ODD`, 0: 0 selects even parity (bit = XOR of data); 1 selects odd parity (bit = inverted XOR).

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: reset, synchronous and active-low.
- `tx_data`, in, 8: byte to send. Sampled only in the acceptance cycle.
- `tx_start`, in, 1: send request. Level is sampled each cycle.
- `tx_busy`, out, 1: high while a frame is in flight.
- `tx_done`, out, 1: one-cycle pulse when a frame completes.
- `UART_Tx`, out, 1: serial line. Idles high.

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Line high, busy low.
  - If `tx_start` = 1: latch `tx_data` into a shift register, compute the parity bit from the latched byte, go to START.
- START: line 0 for `CLKS_PER_BIT` cycles.
- DATA: line = shift[0]. After each bit period, shift right and increment the 3-bit bit index. Leave after index 7 completes.
- PARITY: line = latched parity bit for one bit period.
- STOP:
  - Line 1 for one bit period.
  - At its last cycle, go to IDLE and assert `tx_done` for one cycle.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1.
  - Cleared on acceptance and on every state change.
  - Width is `$clog2(CLKS_PER_BIT)`.
- `tx_start` while busy is ignored. The request is not queued, and the latched data and parity are not disturbed.
- Changing `tx_data` after acceptance has no effect on the frame in flight.
- Reset values (`rst` = 0 at a clock edge):
  - `UART_Tx` = 1, `tx_busy` = 0, `tx_done` = 0.
  - State IDLE; counter, bit index and shift register all 0.
- Reset mid-frame: the line returns high on the next edge, the frame is truncated, and no `tx_done` pulse is generated.

## Timing
- Acceptance edge E: `tx_start` = 1 in IDLE is sampled at E.
  - From E+1, `UART_Tx` = 0 and `tx_busy` = 1. All outputs are registered.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. The frame lasts 11×`CLKS_PER_BIT` cycles (4774 by default).
- Frame end:
  - `tx_done` = 1 and `tx_busy` = 0 during cycle E+1+11×`CLKS_PER_BIT`.
  - The line is already high from the stop bit and stays high.
- Back-to-back: a `tx_start` held high in the `tx_done` cycle is accepted in that cycle. Minimum inter-frame idle on the line is therefore 1 clock.
- `tx_start` held high continuously sends the same latched-per-frame `tx_data` repeatedly, with 1-cycle gaps.
- The line never glitches: `UART_Tx` comes straight from a flop.

## Structure
- Shared package `uart_pkg`, also used by the receiver, holds:
  - the FSM state encoding (IDLE/START/DATA/PARITY/STOP);
  - `FRAME_BITS` = 11 and `DATA_BITS` = 8;
  - the default `CLK_FREQ` and `BAUD`;
  - a `clks_per_bit` function.
- One sub-module: `uart_baud_tick`.
  - A parameterised counter with `clear` input and `tick` output.
  - `tick` is high on the last cycle of each bit period.
  - The FSM advances only on `tick`.

## Test plan
- `tx_data` = 0x0C, default params.
  - Line over 11 bit periods of 434 cycles: 0 | 0,0,1,1,0,0,0,0 | 0 | 1.
  - `tx_busy` high for 4774 cycles; single `tx_done` pulse at E+4775.
- Parity values:
  - 0x08 → parity 1 (one set bit).
  - 0xAA → parity 0.
  - 0x55 → parity 0.
  - With `PARITY_ODD` = 1, 0x07 → parity 0 and 0xFF → parity 1.
- Send 0x12, then pulse `tx_start` with 0x34 mid-frame.
  - Only the 0x12 frame appears.
  - Exactly one `tx_done` pulse.
  - `tx_data` changes after acceptance do not alter the bits.
- Assert `rst` = 0 during DATA bit 3 of 0x0C.
  - Next edge: line 1, busy 0, no `tx_done`.
  - After release, sending 0x08 produces a correct full frame.
- Hold `tx_start` high with 0x0C then 0x08 as back-to-back frames.
  - Frames are separated by exactly a 1-cycle idle high.
- Loopback `UART_Tx` into the receiver.
  - 0x0C and 0x08 are received intact with no parity error.
